// File: rtl/reset_sequencer.sv
// reset_sequencer: merges ext/download reset levels and settled cfg changes into one stretched sys_reset.
// Define RESET_CAUSE_EN to add the rst_cause output.
module reset_sequencer #(
  parameter int CFG_W   = 2,
  parameter int IDX_W   = 8,
  parameter int DL_IDX  = 1,
  parameter int SETTLE  = 4,
  parameter int STRETCH = 15,
  parameter int CNT_W   = 8
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             ext_rst,
  input  logic             ioctl_download,
  input  logic [IDX_W-1:0] ioctl_index,
  input  logic [CFG_W-1:0] cfg,
  output logic [CFG_W-1:0] cfg_active,
  output logic             sys_reset,
  output logic             rst_done,
  output logic             busy
`ifdef RESET_CAUSE_EN
  ,
  output logic [1:0]       rst_cause
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;
  localparam logic [CNT_W-1:0] STR_LD = CNT_W'(STRETCH - 1);
  localparam logic [CNT_W-1:0] SET_LD = CNT_W'(SETTLE - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CFG_W-1:0] cand_q, cand_d, act_q, act_d;
  logic sys_q, done_q, lvl;
  assign lvl = ext_rst | (ioctl_download & (ioctl_index == IDX_W'(DL_IDX)));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    act_d   = act_q;
    if (lvl) begin
      state_d = S_HOLD;
      cnt_d   = STR_LD;
    end else begin
      case (state_q)
        S_IDLE: if (cfg != act_q) begin
          state_d = S_SETTLE;
          cand_d  = cfg;
          cnt_d   = SET_LD;
        end
        S_SETTLE: if (cfg != cand_q) begin
          cand_d = cfg;
          cnt_d  = SET_LD;
        end else if (cnt_q == '0) begin
          act_d   = cand_q;
          state_d = S_HOLD;
          cnt_d   = STR_LD;
        end else cnt_d = cnt_q - CNT_W'(1);
        S_HOLD: if (cnt_q == '0) state_d = S_IDLE;
          else cnt_d = cnt_q - CNT_W'(1);
        default: begin
          state_d = S_HOLD;
          cnt_d   = STR_LD;
        end
      endcase
    end
  end
`ifdef RESET_CAUSE_EN
  logic [1:0] cause_q, cause_d;
  // cfg accept is the only non-level way into HOLD
  assign cause_d = lvl ? (ext_rst ? 2'b01 : 2'b10) :
                   (state_q == S_SETTLE && state_d == S_HOLD) ? 2'b11 : cause_q;
  assign rst_cause = cause_q;
`endif
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_HOLD;
      cnt_q   <= STR_LD;
      cand_q  <= '0;
      act_q   <= '0;
      sys_q   <= 1'b1;
      done_q  <= 1'b0;
`ifdef RESET_CAUSE_EN
      cause_q <= 2'b00;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      act_q   <= act_d;
      sys_q   <= state_d == S_HOLD;
      done_q  <= state_q == S_HOLD && state_d == S_IDLE;
`ifdef RESET_CAUSE_EN
      cause_q <= cause_d;
`endif
    end
  end
  assign cfg_active = act_q;
  assign sys_reset  = sys_q;
  assign rst_done   = done_q;
  assign busy       = state_q != S_IDLE;
endmodule
